// File: rtl/tspi_target.sv
// SPI mode-0 target with a byte-addressed backing memory, all pins oversampled in clk_i.
// Optional status command 0x05 is enabled by defining TSPI_TARGET_STATUS_EN.
module tspi_target #(
   parameter int unsigned Depth      = 256,
   parameter int unsigned AddrWidth  = $clog2(Depth),
   parameter int unsigned SyncStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tspi_clk_i,
   input  logic                 tspi_cs_ni,
   input  logic                 tspi_mosi_i,
   output logic                 tspi_miso_o,
   output logic                 busy_o,
   output logic                 wr_valid_o,
   output logic [AddrWidth-1:0] wr_addr_o,
   output logic [7:0]           wr_data_o,
   output logic                 cmd_err_o
);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddrHi, StAddrLo, StRead, StWrite, StStatus, StIgnore
   } state_e;

   // Pin synchronizers
   logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
   logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
   logic [SyncStages-1:0] mosi_sync_q, mosi_sync_d;
   logic                  sck_last_q, sck_last_d;
   logic                  cs_last_q, cs_last_d;
   logic                  sck_s, cs_s, mosi_s;
   logic                  sck_rise, sck_fall, cs_fall, cs_rise;

   always_comb begin
      sck_sync_d  = {sck_sync_q[SyncStages-2:0], tspi_clk_i};
      cs_sync_d   = {cs_sync_q[SyncStages-2:0], tspi_cs_ni};
      mosi_sync_d = {mosi_sync_q[SyncStages-2:0], tspi_mosi_i};
      sck_s       = sck_sync_q[SyncStages-1];
      cs_s        = cs_sync_q[SyncStages-1];
      mosi_s      = mosi_sync_q[SyncStages-1];
      sck_last_d  = sck_s;
      cs_last_d   = cs_s;
      sck_rise    = sck_s & ~sck_last_q;
      sck_fall    = ~sck_s & sck_last_q;
      cs_fall     = ~cs_s & cs_last_q;
      cs_rise     = cs_s & ~cs_last_q;
   end

   // Left unreset on purpose: a reset with CS held low must not fabricate a CS falling edge.
   always_ff @(posedge clk_i) begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_last_q  <= sck_last_d;
      cs_last_q   <= cs_last_d;
   end

   // Protocol state
   state_e               state_q, state_d;
   logic                 write_mode_q, write_mode_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           tx_q, tx_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 miso_q, miso_d;
   logic                 busy_q, busy_d;
   logic                 wr_valid_q, wr_valid_d;
   logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]           wr_data_q, wr_data_d;
   logic                 cmd_err_q, cmd_err_d;
`ifdef TSPI_TARGET_STATUS_EN
   logic [15:0]          wr_count_q, wr_count_d;
`endif

   logic [7:0]           mem_q [Depth];
   logic                 mem_we;
   logic [7:0]           rx_byte;
   logic [AddrWidth-1:0] lo_addr;

   always_comb begin
      state_d      = state_q;
      write_mode_d = write_mode_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      bit_cnt_d    = bit_cnt_q;
      addr_d       = addr_q;
      miso_d       = miso_q;
      busy_d       = ~cs_s;
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      cmd_err_d    = 1'b0;
      mem_we       = 1'b0;
`ifdef TSPI_TARGET_STATUS_EN
      wr_count_d   = wr_count_q;
`endif
      rx_byte      = {rx_q[6:0], mosi_s};
      // Keep the high address byte already latched, replace only the low byte.
      lo_addr      = AddrWidth'((16'(addr_q) & 16'hFF00) | {8'h00, rx_byte});

      if (state_q == StIdle) begin
         if (cs_fall) state_d = StCmd;
      end else begin
         if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (state_q)
                  StCmd: begin
                     case (rx_byte)
                        8'h03: begin
                           state_d      = StAddrHi;
                           write_mode_d = 1'b0;
                        end
                        8'h02: begin
                           state_d      = StAddrHi;
                           write_mode_d = 1'b1;
                        end
`ifdef TSPI_TARGET_STATUS_EN
                        8'h05: begin
                           state_d = StStatus;
                           tx_d    = wr_count_q[7:0];
                        end
`endif
                        default: begin
                           state_d   = StIgnore;
                           cmd_err_d = 1'b1;
                        end
                     endcase
                  end
                  StAddrHi: begin
                     addr_d  = AddrWidth'({rx_byte, 8'h00});
                     state_d = StAddrLo;
                  end
                  StAddrLo: begin
                     if (write_mode_q) begin
                        addr_d  = lo_addr;
                        state_d = StWrite;
                     end else begin
                        tx_d    = mem_q[lo_addr];
                        addr_d  = lo_addr + AddrWidth'(1);
                        state_d = StRead;
                     end
                  end
                  StRead: begin
                     tx_d   = mem_q[addr_q];
                     addr_d = addr_q + AddrWidth'(1);
                  end
                  StWrite: begin
                     mem_we     = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = addr_q;
                     wr_data_d  = rx_byte;
                     addr_d     = addr_q + AddrWidth'(1);
`ifdef TSPI_TARGET_STATUS_EN
                     wr_count_d = wr_count_q + 16'd1;
`endif
                  end
`ifdef TSPI_TARGET_STATUS_EN
                  StStatus: tx_d = wr_count_q[7:0];
`endif
                  default: ;
               endcase
            end
         end else if (sck_fall) begin
            miso_d = (state_q == StIgnore) ? 1'b0 : tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end

         // A byte completing in the same cycle has already been handled above.
         if (cs_rise) begin
            state_d   = StIdle;
            rx_d      = 8'h00;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            miso_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         write_mode_q <= 1'b0;
         rx_q         <= 8'h00;
         tx_q         <= 8'h00;
         bit_cnt_q    <= 3'd0;
         addr_q       <= '0;
         miso_q       <= 1'b0;
         busy_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'h00;
         cmd_err_q    <= 1'b0;
`ifdef TSPI_TARGET_STATUS_EN
         wr_count_q   <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         write_mode_q <= write_mode_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         bit_cnt_q    <= bit_cnt_d;
         addr_q       <= addr_d;
         miso_q       <= miso_d;
         busy_q       <= busy_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cmd_err_q    <= cmd_err_d;
`ifdef TSPI_TARGET_STATUS_EN
         wr_count_q   <= wr_count_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) mem_q[addr_q] <= rx_byte;
   end

   assign tspi_miso_o = miso_q;
   assign busy_o      = busy_q;
   assign wr_valid_o  = wr_valid_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_tspi_target.sv
// Self-checking bench for tspi_target: bit-level SPI host driving frames, memory/counter model.
module tb_tspi_target;

   logic       clk = 1'b0;
   logic       rst, sck, cs_n, mosi;
   logic       miso, busy, wr_valid, cmd_err;
   logic [7:0] wr_addr, wr_data;

   always #5 clk = ~clk;

   tspi_target #(.Depth(256), .SyncStages(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tspi_clk_i (sck),
      .tspi_cs_ni (cs_n),
      .tspi_mosi_i(mosi),
      .tspi_miso_o(miso),
      .busy_o     (busy),
      .wr_valid_o (wr_valid),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .cmd_err_o  (cmd_err)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] model_mem [256];
   int         model_wr_count = 0;
   logic [7:0] got_addr[$];
   logic [7:0] got_data[$];
   int         err_seen = 0;
   logic [7:0] ftx [16];
   logic [7:0] frx [16];
   logic [7:0] wdat [8];

   // Observed commit stream and error pulses
   always @(negedge clk) begin
      if (wr_valid) begin
         got_addr.push_back(wr_addr);
         got_data.push_back(wr_data);
      end
      if (cmd_err) err_seen++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // SCK = clk/8: MOSI set while low, MISO sampled just before the rising edge
   task automatic xfer_bits(input logic [7:0] v, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = v[7-i];
         wait_clk(4);
         r = {r[6:0], miso};
         sck = 1'b1;
         wait_clk(4);
         sck = 1'b0;
      end
   endtask

   task automatic run_frame(input int n, input int idle);
      cs_n = 1'b0;
      wait_clk(4);
      for (int b = 0; b < n; b++) xfer_bits(ftx[b], 8, frx[b]);
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(idle);
   endtask

   task automatic do_write(input logic [15:0] a, input int n, input int idle);
      got_addr.delete();
      got_data.delete();
      ftx[0] = 8'h02;
      ftx[1] = a[15:8];
      ftx[2] = a[7:0];
      for (int i = 0; i < n; i++) begin
         ftx[3+i] = wdat[i];
         model_mem[(int'(a[7:0]) + i) % 256] = wdat[i];
         model_wr_count++;
      end
      run_frame(3 + n, idle);
   endtask

   task automatic do_read(input logic [15:0] a, input int n, input int idle);
      ftx[0] = 8'h03;
      ftx[1] = a[15:8];
      ftx[2] = a[7:0];
      for (int i = 0; i < n; i++) ftx[3+i] = 8'($urandom);
      run_frame(3 + n, idle);
   endtask

   task automatic test_reset();
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      wait_clk(5);
      n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
      n_checks++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
      n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
      n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
      rst = 1'b0;
      model_wr_count = 0;
      wait_clk(5);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_busy_latency();
      cs_n = 1'b0;
      wait_clk(2);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_early: got %b want 0", busy); end
      wait_clk(1);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b want 1", busy); end
      cs_n = 1'b1;
      wait_clk(3);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b want 0", busy); end
      wait_clk(4);
   endtask

   task automatic test_write_read();
      wdat[0] = 8'hA5; wdat[1] = 8'h5A;
      do_write(16'h0010, 2, 8);
      n_checks++; if (got_addr.size() !== 2) begin n_fail++; $display("FAIL wr_count: got %0d want 2", got_addr.size()); end
      else begin
         n_checks++; if (got_addr[0] !== 8'h10 || got_data[0] !== 8'hA5) begin n_fail++;
            $display("FAIL wr0: got (%h,%h) want (10,a5)", got_addr[0], got_data[0]); end
         n_checks++; if (got_addr[1] !== 8'h11 || got_data[1] !== 8'h5A) begin n_fail++;
            $display("FAIL wr1: got (%h,%h) want (11,5a)", got_addr[1], got_data[1]); end
      end
      do_read(16'h0010, 2, 8);
      n_checks++; if (frx[3] !== 8'hA5) begin n_fail++; $display("FAIL rd0: got %h want a5", frx[3]); end
      n_checks++; if (frx[4] !== 8'h5A) begin n_fail++; $display("FAIL rd1: got %h want 5a", frx[4]); end
   endtask

   task automatic test_wrap();
      wdat[0] = 8'h11; wdat[1] = 8'h22;
      do_write(16'h00FF, 2, 8);
      n_checks++; if (got_addr.size() !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", got_addr.size()); end
      else begin
         n_checks++; if (got_addr[0] !== 8'hFF || got_data[0] !== 8'h11) begin n_fail++;
            $display("FAIL wrap_wr0: got (%h,%h) want (ff,11)", got_addr[0], got_data[0]); end
         n_checks++; if (got_addr[1] !== 8'h00 || got_data[1] !== 8'h22) begin n_fail++;
            $display("FAIL wrap_wr1: got (%h,%h) want (00,22)", got_addr[1], got_data[1]); end
      end
      do_read(16'h00FF, 2, 8);
      n_checks++; if (frx[3] !== 8'h11) begin n_fail++; $display("FAIL wrap_rd0: got %h want 11", frx[3]); end
      n_checks++; if (frx[4] !== 8'h22) begin n_fail++; $display("FAIL wrap_rd1: got %h want 22", frx[4]); end
   endtask

   task automatic test_abort();
      logic [7:0] r;
      wdat[0] = 8'h3C;
      do_write(16'h0020, 1, 8);
      // Partial byte then CS high
      got_addr.delete(); got_data.delete();
      cs_n = 1'b0;
      wait_clk(4);
      xfer_bits(8'h02, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h20, 8, r);
      xfer_bits(8'hC0, 4, r);
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(8);
      n_checks++; if (got_addr.size() !== 0) begin n_fail++; $display("FAIL abort_writes: got %0d want 0", got_addr.size()); end
      do_read(16'h0020, 1, 8);
      n_checks++; if (frx[3] !== model_mem[8'h20]) begin n_fail++;
         $display("FAIL abort_rd: got %h want %h", frx[3], model_mem[8'h20]); end
      // Same frame interrupted by reset
      got_addr.delete(); got_data.delete();
      cs_n = 1'b0;
      wait_clk(4);
      xfer_bits(8'h02, 8, r); xfer_bits(8'h00, 8, r); xfer_bits(8'h20, 8, r);
      xfer_bits(8'hC0, 4, r);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      model_wr_count = 0;
      n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b want 0", miso); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (wr_addr !== 8'h00 || wr_data !== 8'h00) begin n_fail++;
         $display("FAIL rst_wr_regs: got (%h,%h) want (00,00)", wr_addr, wr_data); end
      xfer_bits(8'hEE, 8, r);
      xfer_bits(8'hEE, 8, r);
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(8);
      n_checks++; if (got_addr.size() !== 0) begin n_fail++; $display("FAIL rst_writes: got %0d want 0", got_addr.size()); end
      do_read(16'h0020, 1, 8);
      n_checks++; if (frx[3] !== model_mem[8'h20]) begin n_fail++;
         $display("FAIL rst_rd: got %h want %h", frx[3], model_mem[8'h20]); end
   endtask

   task automatic test_unknown();
      int err0;
      err0 = err_seen;
      got_addr.delete(); got_data.delete();
      ftx[0] = 8'h7E; ftx[1] = 8'hFF; ftx[2] = 8'hA5; ftx[3] = 8'h5A;
      run_frame(4, 8);
      n_checks++; if (err_seen - err0 !== 1) begin n_fail++; $display("FAIL unk_err: got %0d pulses want 1", err_seen - err0); end
      for (int i = 1; i < 4; i++) begin
         n_checks++; if (frx[i] !== 8'h00) begin n_fail++; $display("FAIL unk_miso%0d: got %h want 00", i, frx[i]); end
      end
      n_checks++; if (got_addr.size() !== 0) begin n_fail++; $display("FAIL unk_writes: got %0d want 0", got_addr.size()); end
   endtask

   task automatic test_status();
      int         err0;
      logic [7:0] exp_st;
      int         exp_err;
      wdat[0] = 8'($urandom); wdat[1] = 8'($urandom);
      do_write(16'($urandom), 2, 8);
      n_checks++; if (got_addr.size() !== 2) begin n_fail++; $display("FAIL st_writes: got %0d want 2", got_addr.size()); end
      err0 = err_seen;
      ftx[0] = 8'h05; ftx[1] = 8'h00; ftx[2] = 8'h00;
      run_frame(3, 8);
`ifdef TSPI_TARGET_STATUS_EN
      exp_st  = 8'(model_wr_count);
      exp_err = 0;
`else
      exp_st  = 8'h00;
      exp_err = 1;
`endif
      n_checks++; if (frx[1] !== exp_st) begin n_fail++; $display("FAIL status0: got %h want %h", frx[1], exp_st); end
      n_checks++; if (frx[2] !== exp_st) begin n_fail++; $display("FAIL status1: got %h want %h", frx[2], exp_st); end
      n_checks++; if (err_seen - err0 !== exp_err) begin n_fail++;
         $display("FAIL status_err: got %0d want %0d", err_seen - err0, exp_err); end
   endtask

   task automatic test_back_to_back();
      wdat[0] = 8'h77;
      do_write(16'h0040, 1, 4);
      do_read(16'h0040, 1, 4);
      n_checks++; if (frx[3] !== 8'h77) begin n_fail++; $display("FAIL b2b_rd: got %h want 77", frx[3]); end
      wdat[0] = 8'h88;
      do_write(16'h0041, 1, 4);
      n_checks++; if (got_addr.size() !== 1 || got_data[0] !== 8'h88) begin n_fail++;
         $display("FAIL b2b_wr: got %0d commits want 1 of 88", got_addr.size()); end
      do_read(16'h0040, 2, 4);
      n_checks++; if (frx[3] !== 8'h77 || frx[4] !== 8'h88) begin n_fail++;
         $display("FAIL b2b_rd2: got %h %h want 77 88", frx[3], frx[4]); end
   endtask

   task automatic test_random();
      logic [15:0] a;
      int          n;
      for (int it = 0; it < 6; it++) begin
         a = 16'($urandom);
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
         do_write(a, n, $urandom_range(4, 10));
         n_checks++; if (got_addr.size() !== n) begin n_fail++;
            $display("FAIL rnd_count%0d: got %0d want %0d", it, got_addr.size(), n); end
         else begin
            for (int i = 0; i < n; i++) begin
               n_checks++;
               if (got_addr[i] !== 8'(int'(a[7:0]) + i) || got_data[i] !== wdat[i]) begin n_fail++;
                  $display("FAIL rnd_wr%0d_%0d: got (%h,%h) want (%h,%h)", it, i, got_addr[i],
                           got_data[i], 8'(int'(a[7:0]) + i), wdat[i]); end
            end
         end
         do_read(a, n, $urandom_range(4, 10));
         for (int i = 0; i < n; i++) begin
            n_checks++;
            if (frx[3+i] !== model_mem[(int'(a[7:0]) + i) % 256]) begin n_fail++;
               $display("FAIL rnd_rd%0d_%0d: got %h want %h", it, i, frx[3+i],
                        model_mem[(int'(a[7:0]) + i) % 256]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_busy_latency();
      test_write_read();
      test_wrap();
      test_abort();
      test_unknown();
      test_status();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
